// File: rtl/his_reader_fsm_pkg.sv
// ---------------------------------------------------------------------------
// his_reader_fsm_pkg
// Shared constants and types for the histogram reader.
//   BIN_NUM / PIXEL_NUM : histogram geometry (bins per pixel, pixels per frame)
//   BIN_W / PIX_W       : index widths; RAM address is {pixel, bin}
//   CNT_W               : width of one histogram count
//   state_t             : reader FSM encoding (IDLE=00, RUN=01, DONE=10)
// ---------------------------------------------------------------------------
package his_reader_fsm_pkg;

    localparam int BIN_NUM   = 16;
    localparam int PIXEL_NUM = 4;
    localparam int BIN_W     = 4;
    localparam int PIX_W     = 2;
    localparam int CNT_W     = 8;
    localparam int ADDR_W    = PIX_W + BIN_W;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_NUM - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/his_reader_fsm_if.sv
// ---------------------------------------------------------------------------
// his_reader_fsm_if
// Bundles the histogram RAM port and the output beat stream of the reader.
//   RAM side   : ram_rd_en, ram_bank, ram_addr, ram_rd_data (1-cycle latency),
//                ram_clr_en, ram_clr_addr (write-zero)
//   Stream side: out_valid/out_ready handshake, out_count, out_bin,
//                out_pixel, out_last
// Modports: master = reader, slave = RAM + stream consumer.
// ---------------------------------------------------------------------------
interface his_reader_fsm_if;
    import his_reader_fsm_pkg::*;

    logic              ram_rd_en;
    logic              ram_bank;
    logic [ADDR_W-1:0] ram_addr;
    logic [CNT_W-1:0]  ram_rd_data;
    logic              ram_clr_en;
    logic [ADDR_W-1:0] ram_clr_addr;

    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic [BIN_W-1:0]  out_bin;
    logic [PIX_W-1:0]  out_pixel;
    logic              out_last;

    modport master (
        output ram_rd_en, ram_bank, ram_addr, ram_clr_en, ram_clr_addr,
        input  ram_rd_data,
        output out_valid, out_count, out_bin, out_pixel, out_last,
        input  out_ready
    );

    modport slave (
        input  ram_rd_en, ram_bank, ram_addr, ram_clr_en, ram_clr_addr,
        output ram_rd_data,
        input  out_valid, out_count, out_bin, out_pixel, out_last,
        output out_ready
    );

endinterface

// File: rtl/his_reader_fsm_peak_tracker.sv
// ---------------------------------------------------------------------------
// his_peak_tracker
// Per-pixel maximum tracker for the histogram reader. Only built when the
// PEAK_DETECT_EN macro is defined.
//   clk, res   : clock, asynchronous active-high reset
//   beat       : a beat is accepted on the output stream this cycle
//   count/bin  : payload of that beat
//   last       : beat is the final bin of its pixel
//   peak_valid : one-cycle pulse after the last beat of a pixel is accepted
//   peak_bin / peak_count : lowest bin holding the pixel's maximum count
// ---------------------------------------------------------------------------
`ifdef PEAK_DETECT_EN
module his_peak_tracker
    import his_reader_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic             beat,
    input  logic [CNT_W-1:0] count,
    input  logic [BIN_W-1:0] bin,
    input  logic             last,
    output logic             peak_valid,
    output logic [BIN_W-1:0] peak_bin,
    output logic [CNT_W-1:0] peak_count
);

    logic [CNT_W-1:0] max_q;
    logic [BIN_W-1:0] max_bin_q;
    logic             take;
    logic [CNT_W-1:0] max_new;
    logic [BIN_W-1:0] max_bin_new;

    // Bin 0 opens a new pixel; afterwards only a strictly larger count wins,
    // so ties stay on the lowest bin.
    assign take        = beat && ((bin == '0) || (count > max_q));
    assign max_new     = take ? count : max_q;
    assign max_bin_new = take ? bin   : max_bin_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            max_q      <= '0;
            max_bin_q  <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_count <= '0;
        end else begin
            if (beat) begin
                max_q     <= max_new;
                max_bin_q <= max_bin_new;
            end
            peak_valid <= beat && last;
            if (beat && last) begin
                peak_bin   <= max_bin_new;
                peak_count <= max_new;
            end
        end
    end

endmodule
`endif

// File: rtl/his_reader_fsm.sv
// ---------------------------------------------------------------------------
// his_reader_fsm
// Reads out a completed histogram bank bin by bin after his_done, streams
// each count on a valid/ready interface and clears every bin it has read.
// Optional per-pixel peak detection is enabled with the PEAK_DETECT_EN macro;
// without it the peak outputs are tied to zero.
//   clk, res          : clock, asynchronous active-high reset
//   his_done/his_bank : acquisition-complete pulse and the bank it filled
//   bus (master)      : histogram RAM read/clear port and output beat stream
//   busy              : frame readout in progress (RUN or DONE)
//   frame_done        : one-cycle pulse after the final beat is accepted
//   overrun           : sticky, his_done arrived while busy
//   peak_valid/peak_bin/peak_count : per-pixel peak result
// ---------------------------------------------------------------------------
module his_reader_fsm
    import his_reader_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              res,
    input  logic              his_done,
    input  logic              his_bank,
    his_reader_fsm_if.master  bus,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic              peak_valid,
    output logic [BIN_W-1:0]  peak_bin,
    output logic [CNT_W-1:0]  peak_count
);

    state_t            state, state_nxt;
    logic              start;
    logic              bank_q;
    logic [PIX_W-1:0]  pix_cnt;
    logic [BIN_W-1:0]  bin_cnt;
    logic              all_issued;
    logic              rd_pending;
    logic [ADDR_W-1:0] pend_addr;
    logic              out_valid_q;
    logic [CNT_W-1:0]  out_count_q;
    logic [BIN_W-1:0]  out_bin_q;
    logic [PIX_W-1:0]  out_pixel_q;
    logic              out_last_q;
    logic              rd_en;
    logic              accept;
    logic              final_accept;

    assign accept       = out_valid_q && bus.out_ready;
    assign final_accept = accept && out_last_q && (out_pixel_q == LAST_PIX);

    // One read at a time, and only when the output register will be free to
    // take the data; all_issued stops the counters from wrapping into a
    // second pass over the bank.
    assign rd_en = (state == RUN) && !rd_pending && !all_issued
                   && (!out_valid_q || bus.out_ready);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge res) begin
        if (res) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (his_done) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (final_accept) state_nxt = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            bank_q      <= 1'b0;
            pix_cnt     <= '0;
            bin_cnt     <= '0;
            all_issued  <= 1'b0;
            rd_pending  <= 1'b0;
            pend_addr   <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_bin_q   <= '0;
            out_pixel_q <= '0;
            out_last_q  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (start) begin
                bank_q     <= his_bank;
                pix_cnt    <= '0;
                bin_cnt    <= '0;
                all_issued <= 1'b0;
            end else if (rd_en) begin
                pend_addr <= {pix_cnt, bin_cnt};
                if (bin_cnt == LAST_BIN) begin
                    if (pix_cnt == LAST_PIX) begin
                        all_issued <= 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + PIX_W'(1);
                        bin_cnt <= '0;
                    end
                end else begin
                    bin_cnt <= bin_cnt + BIN_W'(1);
                end
            end

            rd_pending <= rd_en;

            // Read data is valid in the cycle after the strobe; capture it
            // together with the address it came from.
            if (rd_pending) begin
                out_valid_q               <= 1'b1;
                out_count_q               <= bus.ram_rd_data;
                {out_pixel_q, out_bin_q}  <= pend_addr;
                out_last_q                <= (pend_addr[BIN_W-1:0] == LAST_BIN);
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end

            if (his_done && (state != IDLE)) overrun <= 1'b1;
        end
    end

    assign bus.ram_rd_en    = rd_en;
    assign bus.ram_bank     = bank_q;
    assign bus.ram_addr     = {pix_cnt, bin_cnt};
    // The clear of a bin rides on the cycle its data comes back.
    assign bus.ram_clr_en   = rd_pending;
    assign bus.ram_clr_addr = pend_addr;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_bin      = out_bin_q;
    assign bus.out_pixel    = out_pixel_q;
    assign bus.out_last     = out_last_q;

`ifdef PEAK_DETECT_EN
    his_peak_tracker u_peak (
        .clk        (clk),
        .res        (res),
        .beat       (accept),
        .count      (out_count_q),
        .bin        (out_bin_q),
        .last       (out_last_q),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_count (peak_count)
    );
`else
    assign peak_valid = 1'b0;
    assign peak_bin   = '0;
    assign peak_count = '0;
`endif

endmodule

// File: doc/his_reader_fsm.md
HIS_READER_FSM -- requirements
Module: his_reader_fsm

Interface
REQ-001 Constants: BIN_NUM=16, PIXEL_NUM=4, BIN_W=4, PIX_W=2, CNT_W=8; all live in parametersSiFH.vh.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 res  in  1  reset, asynchronous, active-high.
REQ-005 his_done  in  1  one-cycle pulse from the histogram builder: acquisition complete.
REQ-006 his_bank  in  1  completed bank index, sampled when his_done=1.
REQ-007 ram_rd_en  out  1  histogram RAM read strobe.
REQ-008 ram_bank  out  1  bank for reads and clears.
REQ-009 ram_addr  out  PIX_W+BIN_W  read address, {pixel,bin}.
REQ-010 ram_rd_data  in  CNT_W  read data, valid exactly one cycle after ram_rd_en.
REQ-011 ram_clr_en  out  1  write-zero strobe.
REQ-012 ram_clr_addr  out  PIX_W+BIN_W  clear address.
REQ-013 out_valid, out_ready  out/in  1  stream handshake.
REQ-014 out_count / out_bin / out_pixel  out  CNT_W / BIN_W / PIX_W  beat payload.
REQ-015 out_last  out  1  marks bin BIN_NUM-1 of each pixel.
REQ-016 busy  out  1  frame readout in progress.
REQ-017 frame_done  out  1  one-cycle pulse after the final beat is accepted.
REQ-018 overrun  out  1  sticky error flag.
REQ-019 peak_valid / peak_bin / peak_count  out  1 / BIN_W / CNT_W  per-pixel peak result.

Function
REQ-020 FSM states: IDLE, RUN, DONE. IDLE->RUN on his_done. RUN->DONE when the final beat (pixel PIXEL_NUM-1, bin BIN_NUM-1) is accepted. DONE->IDLE unconditionally after one cycle.
REQ-021 On his_done in IDLE: latch his_bank into ram_bank; zero pixel and bin counters. The first ram_rd_en is issued in the following cycle.
REQ-022 Read issue rule: ram_rd_en=1 iff state=RUN, no read in flight, and (out_valid=0 or out_ready=1). Throughput is therefore one beat per 2 cycles with out_ready held high.
REQ-023 The cycle after a read: register ram_rd_data into out_count with its bin and pixel, set out_valid=1, pulse ram_clr_en with ram_clr_addr set to the address just read.
REQ-024 out_valid holds, with payload stable, until out_valid&&out_ready; no new read is issued while the output is stalled.
REQ-025 Traversal order: bin increments fastest, 0..BIN_NUM-1, then pixel increments. Counters do not wrap within a frame.
REQ-026 busy=1 in RUN and DONE. frame_done=1 in DONE only.
REQ-027 his_done while busy is ignored for readout and sets overrun=1; overrun clears only on res.
REQ-028 his_done and final-beat acceptance in the same cycle count as an overrun; no new frame starts.
REQ-029 Every bin read in a frame is cleared exactly once; no clears occur outside RUN.

Reset
REQ-030 res=1 forces: state=IDLE, all outputs 0, counters 0, in-flight read discarded, overrun=0.
REQ-031 res mid-frame aborts the frame; the remaining bins are not cleared.

Configuration
REQ-032 Macro PEAK_DETECT_EN defined: per pixel, track the maximum out_count over accepted beats. A strictly greater value replaces the current peak, so ties keep the lowest bin. peak_valid pulses one cycle after the out_last beat is accepted, with that pixel's peak_bin and peak_count. The tracker resets at each pixel start.
REQ-033 PEAK_DETECT_EN undefined: no tracker is instantiated; peak_valid, peak_bin and peak_count are tied to 0. All other behaviour is identical.

Structure
REQ-034 parametersSiFH.vh holds BIN_NUM, PIXEL_NUM, BIN_W, PIX_W, CNT_W and the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
REQ-035 One sub-module, his_peak_tracker (compare/update, per-pixel reset), is instantiated only under PEAK_DETECT_EN.

Verification
REQ-036 Reset: assert res with his_done toggling -> all outputs 0; no ram_rd_en.
REQ-037 RAM bank1 preloaded with {p,b}->p*16+b, his_done with his_bank=1, out_ready=1 -> 64 beats in order; out_count=p*16+b; out_last on b=15; 64 clears to bank 1; frame_done pulses once; busy falls after it.
REQ-038 out_ready=0 for 5 cycles while beat 3 is valid -> payload stable, zero ram_rd_en; beat 4 arrives 2 cycles after ready rises.
REQ-039 his_done at beat 10 -> overrun=1; beats 11..63 unchanged; no second frame.
REQ-040 PEAK_DETECT_EN, pixel 2 bins 5 and 9 = 200, other bins <200 -> peak_valid for pixel 2 with peak_bin=5, peak_count=200.
REQ-041 res at beat 20 -> next cycle: outputs 0, state IDLE; bins 20..63 are not cleared.
